arcade_input_mapper: RTL and testbench

Parametrised successor to the hard-coded PS/2 keyboard case-decode and joystick OR logic in the arcade top levels. It uses a runtime-loadable key table with NUM_SLOTS entries. Each slot merges keyboard state with a joystick bit. Coin slots get minimum-width pulse stretching, and fire slots get optional autofire. It sits in emu between hps_io (ps2_key, joystick) and the game core button inputs, and it runs on the core system clock.

---
 rtl/arcade_input_pkg.sv | 42 ++++
 rtl/input_slot_shaper.sv | 82 ++++++++
 rtl/arcade_input_mapper.sv | 88 ++++++++
 tb/tb_arcade_input_mapper.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared PS/2 scan codes, slot kinds and key-map helpers for the arcade input mapper.
package arcade_input_pkg;

  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_LCTRL = 9'h014;
  localparam logic [8:0] KEY_1     = 9'h016;
  localparam logic [8:0] KEY_2     = 9'h01E;
  localparam logic [8:0] KEY_5     = 9'h02E;
  localparam logic [8:0] KEY_6     = 9'h036;
  localparam logic [8:0] KEY_F1    = 9'h005;
  localparam logic [8:0] KEY_F2    = 9'h006;

  localparam int unsigned MAX_SLOTS = 32;

  typedef enum logic [1:0] {
    SLOT_PLAIN,
    SLOT_COIN,
    SLOT_AF
  } slot_kind_t;

  // Returns map with the 9-bit entry for slot replaced by code; chain calls to build a default map.
  function automatic logic [9*MAX_SLOTS-1:0] map_set(input logic [9*MAX_SLOTS-1:0] map,
                                                     input int unsigned slot,
                                                     input logic [8:0] code);
    logic [9*MAX_SLOTS-1:0] r;
    r = map;
    r[9*slot +: 9] = code;
    return r;
  endfunction

  // Coin takes precedence when a slot is flagged as both coin and autofire.
  function automatic slot_kind_t slot_kind(input logic coin, input logic af);
    if (coin)    return SLOT_COIN;
    else if (af) return SLOT_AF;
    else         return SLOT_PLAIN;
  endfunction

endpackage

// File: rtl/input_slot_shaper.sv
// Per-slot output stage: registered button with coin pulse stretching or autofire.
module input_slot_shaper
  import arcade_input_pkg::*;
#(
  parameter slot_kind_t  KIND      = SLOT_PLAIN,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned COIN_HOLD = 1100000,
  parameter int unsigned AF_DIV    = 183333
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic m,
  input  logic af_en,
  output logic btn
);

  localparam logic [CNT_W-1:0] COIN_RELOAD = CNT_W'(COIN_HOLD - 1);
  localparam logic [CNT_W-1:0] AF_RELOAD   = CNT_W'(AF_DIV - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic             m_q;
  logic             phase_q, phase_n;
  logic             run_q, run_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             btn_n;
  logic             rise;

  assign rise = m & ~m_q;

  always_comb begin
    cnt_n   = '0;
    phase_n = 1'b0;
    run_n   = 1'b0;
    btn_n   = m;
    unique case (KIND)
      SLOT_COIN: begin
        if (rise && cnt_q == '0) cnt_n = COIN_RELOAD;
        else if (cnt_q != '0)    cnt_n = cnt_q - ONE;
        btn_n = m | (cnt_q != '0);
      end
      SLOT_AF: begin
        // run_q keeps a hold that started with autofire off from firing until the next press.
        if (af_en && m) begin
          if (rise) begin
            run_n   = 1'b1;
            phase_n = 1'b1;
            cnt_n   = AF_RELOAD;
          end else if (run_q) begin
            run_n = 1'b1;
            if (cnt_q == '0) begin
              phase_n = ~phase_q;
              cnt_n   = AF_RELOAD;
            end else begin
              phase_n = phase_q;
              cnt_n   = cnt_q - ONE;
            end
          end
          btn_n = phase_n;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      m_q     <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      run_q   <= 1'b0;
      btn     <= 1'b0;
    end else begin
      m_q     <= m;
      cnt_q   <= cnt_n;
      phase_q <= phase_n;
      run_q   <= run_n;
      btn     <= btn_n;
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Runtime-loadable PS/2 key table merged with joystick bits, feeding per-slot output shapers.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned            NUM_SLOTS   = 16,
  parameter int unsigned            IDX_W       = $clog2(NUM_SLOTS),
  parameter logic [NUM_SLOTS*9-1:0] DEFAULT_MAP = '0,
  parameter logic [NUM_SLOTS-1:0]   COIN_MASK   = '0,
  parameter logic [NUM_SLOTS-1:0]   AF_MASK     = '0,
  parameter int unsigned            COIN_HOLD   = 1100000,
  parameter int unsigned            AF_DIV      = 183333,
  parameter int unsigned            CNT_W       = 21
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic [NUM_SLOTS-1:0] joy_in,
  input  logic                 cfg_wr,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [8:0]           cfg_code,
  input  logic                 af_en,
  input  logic                 inputs_en,
  output logic [NUM_SLOTS-1:0] btn_out,
  output logic [NUM_SLOTS-1:0] key_state
);

  if (NUM_SLOTS < 2 || NUM_SLOTS > MAX_SLOTS || COIN_HOLD < 1 || AF_DIV < 1 ||
      64'(COIN_HOLD) >= (64'd1 << CNT_W) || 64'(AF_DIV) >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("arcade_input_mapper: NUM_SLOTS, COIN_HOLD or AF_DIV out of range for CNT_W");
  end

  logic [8:0]           key_table [NUM_SLOTS];
  logic                 tog_q;
  logic                 primed_q;
  logic                 key_event;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] merged;

  // primed_q suppresses the toggle comparison until tog_q has sampled a real value after reset.
  assign key_event = primed_q & (ps2_key[10] ^ tog_q);
  assign merged    = key_state | joy_in;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      hit[i] = (key_table[i] == ps2_key[8:0]) && (ps2_key[8:0] != 9'h000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q     <= 1'b0;
      primed_q  <= 1'b0;
      key_state <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++)
        key_table[i] <= DEFAULT_MAP[9*i +: 9];
    end else begin
      tog_q    <= ps2_key[10];
      primed_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (cfg_wr && cfg_idx == IDX_W'(i)) begin
          key_table[i] <= cfg_code;
          key_state[i] <= 1'b0;
        end else if (!inputs_en) begin
          key_state[i] <= 1'b0;
        end else if (key_event && hit[i]) begin
          key_state[i] <= ps2_key[9];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    input_slot_shaper #(
      .KIND      (slot_kind(COIN_MASK[g], AF_MASK[g])),
      .CNT_W     (CNT_W),
      .COIN_HOLD (COIN_HOLD),
      .AF_DIV    (AF_DIV)
    ) u_shaper (
      .clk   (clk),
      .reset (reset),
      .en    (inputs_en),
      .m     (merged[g]),
      .af_en (af_en),
      .btn   (btn_out[g])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed literal checks plus a randomized run against a timing model.
module tb_arcade_input_mapper;
  import arcade_input_pkg::*;

  localparam int unsigned NS    = 12;
  localparam int unsigned IW    = 4;
  localparam int unsigned HOLD  = 10;
  localparam int unsigned DIV   = 4;
  localparam logic [NS-1:0] CMASK = 12'h088;
  localparam logic [NS-1:0] AMASK = 12'h190;
  localparam logic [9*MAX_SLOTS-1:0] MAP_ALL =
    map_set(map_set(map_set(map_set(map_set(map_set(map_set(map_set(map_set(map_set(map_set(
      '0, 0, KEY_SPACE), 1, KEY_F1), 2, KEY_1), 3, KEY_5), 4, KEY_LCTRL), 5, KEY_1),
      7, KEY_6), 8, KEY_UP), 9, KEY_DOWN), 10, KEY_LEFT), 11, KEY_RIGHT);
  localparam logic [9*NS-1:0] DEF_MAP = MAP_ALL[9*NS-1:0];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   ps2_key = '0;
  logic [NS-1:0] joy_in = '0;
  logic          cfg_wr = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [8:0]    cfg_code = '0;
  logic          af_en = 1'b1;
  logic          inputs_en = 1'b1;
  logic [NS-1:0] btn_out, key_state;

  int n_checks = 0;
  int n_fail = 0;

  arcade_input_mapper #(
    .NUM_SLOTS(NS), .IDX_W(IW), .DEFAULT_MAP(DEF_MAP), .COIN_MASK(CMASK), .AF_MASK(AMASK),
    .COIN_HOLD(HOLD), .AF_DIV(DIV), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in), .cfg_wr(cfg_wr),
    .cfg_idx(cfg_idx), .cfg_code(cfg_code), .af_en(af_en), .inputs_en(inputs_en),
    .btn_out(btn_out), .key_state(key_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keyboard table/state as arrays; output timing from elapsed cycles since each press.
  bit [8:0]    mtab [NS];
  bit [NS-1:0] mks, exp_btn, mprev, coin_have, af_run;
  longint      start_t [NS];
  longint      t = 0;
  bit          primed = 0, mtog = 0, model_ok = 0;

  task automatic model_step();
    bit [NS-1:0] m;
    bit ev, rise, running;
    longint d;
    if (reset) begin
      for (int i = 0; i < NS; i++) mtab[i] = DEF_MAP[9*i +: 9];
      mks = '0; exp_btn = '0; mprev = '0; coin_have = '0; af_run = '0;
      primed = 0; mtog = 0; model_ok = 1;
    end else begin
      m = mks | joy_in;
      if (!inputs_en) begin
        exp_btn = '0; mprev = '0; coin_have = '0; af_run = '0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          rise = m[i] & ~mprev[i];
          if (CMASK[i]) begin
            d = t - start_t[i];
            running = coin_have[i] && d >= 1 && d < HOLD;
            exp_btn[i] = m[i] | running;
            if (rise && !running) begin coin_have[i] = 1; start_t[i] = t; end
          end else if (AMASK[i] && af_en && m[i]) begin
            if (rise) begin af_run[i] = 1; start_t[i] = t; end
            exp_btn[i] = af_run[i] && (((t - start_t[i]) / DIV) % 2 == 0);
          end else begin
            af_run[i] = 0;
            exp_btn[i] = m[i];
          end
        end
        mprev = m;
      end
      ev = primed && (ps2_key[10] != mtog);
      for (int i = 0; i < NS; i++) begin
        if (cfg_wr && int'(cfg_idx) == i) begin mtab[i] = cfg_code; mks[i] = 0; end
        else if (!inputs_en) mks[i] = 0;
        else if (ev && ps2_key[8:0] != 9'h000 && mtab[i] == ps2_key[8:0]) mks[i] = ps2_key[9];
      end
      mtog = ps2_key[10];
      primed = 1;
    end
    t++;
  endtask

  always begin
    @(posedge clk);
    model_step();
    #1;
    if (model_ok) begin
      check("model btn_out", 32'(btn_out), 32'(exp_btn));
      check("model key_state", 32'(key_state), 32'(mks));
    end
  end

  task automatic key_evt(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic coin_count(input int second_at, input int hold, output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) joy_in[3] = 1'b1;
      if (k == hold) joy_in[3] = 1'b0;
      if (second_at > 0 && k == second_at) joy_in[3] = 1'b1;
      if (second_at > 0 && k == second_at + 1) joy_in[3] = 1'b0;
      @(negedge clk);
      cnt += int'(btn_out[3]);
    end
  endtask

  task automatic af_pattern(output logic [19:0] bits);
    joy_in[4] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bits[19-k] = btn_out[4];
    end
    joy_in[4] = 1'b0;
    @(negedge clk);
    check("af release", 32'(btn_out[4]), 32'd0);
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [8:0]  codes [14] = '{KEY_SPACE, KEY_F1, KEY_1, KEY_5, KEY_LCTRL, KEY_6, KEY_UP, KEY_DOWN,
                              KEY_LEFT, KEY_RIGHT, 9'h01C, 9'h000, KEY_2, KEY_F2};
  int          cnt;
  logic [19:0] pat;

  initial begin
    idle(3);
    check("reset btn_out", 32'(btn_out), 32'd0);
    check("reset key_state", 32'(key_state), 32'd0);
    reset = 1'b0;
    idle(2);

    // Map-hit latency
    key_evt(1'b1, KEY_SPACE);
    check("space ks 1 edge", 32'(key_state), 32'h001);
    check("space btn 1 edge", 32'(btn_out), 32'h000);
    @(negedge clk);
    check("space btn 2 edges", 32'(btn_out), 32'h001);
    key_evt(1'b0, KEY_SPACE);
    check("space release ks", 32'(key_state), 32'h000);
    @(negedge clk);
    check("space release btn", 32'(btn_out), 32'h000);

    // Dual mapping and code 0
    key_evt(1'b1, KEY_1);
    check("dual map ks", 32'(key_state), 32'h024);
    key_evt(1'b1, 9'h000);
    check("code0 no match", 32'(key_state), 32'h024);
    key_evt(1'b0, KEY_1);
    check("dual release", 32'(key_state), 32'h000);
    idle(2);

    // Coin stretch
    coin_count(0, 1, cnt);
    check("coin 1-cycle pulse", 32'(cnt), 32'd10);
    coin_count(5, 1, cnt);
    check("coin no retrigger", 32'(cnt), 32'd10);
    coin_count(0, 25, cnt);
    check("coin held 25", 32'(cnt), 32'd25);

    // Autofire
    af_pattern(pat);
    check("autofire pattern", 32'(pat), 32'h000F0F0F);
    af_en = 1'b0;
    af_pattern(pat);
    check("autofire off solid", 32'(pat), 32'h000FFFFF);
    af_en = 1'b1;

    // Config collision
    cfg_wr = 1'b1; cfg_idx = 4'd1; cfg_code = 9'h01C;
    key_evt(1'b1, 9'h01C);
    cfg_wr = 1'b0;
    check("cfg wins collision", 32'(key_state), 32'h000);
    key_evt(1'b1, 9'h01C);
    check("new code press", 32'(key_state), 32'h002);
    cfg_wr = 1'b1; cfg_idx = 4'd12; cfg_code = KEY_SPACE;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("cfg idx out of range", 32'(key_state), 32'h002);
    key_evt(1'b0, 9'h01C);
    idle(2);

    // Freeze
    key_evt(1'b1, KEY_SPACE);
    @(negedge clk);
    check("held before freeze", 32'(btn_out), 32'h001);
    inputs_en = 1'b0;
    @(negedge clk);
    check("freeze btn", 32'(btn_out), 32'h000);
    check("freeze ks", 32'(key_state), 32'h000);
    key_evt(1'b1, KEY_F1);
    inputs_en = 1'b1;
    idle(3);
    check("unfreeze no replay", 32'(btn_out), 32'h000);

    // Reset mid coin count
    joy_in[3] = 1'b1;
    @(negedge clk);
    joy_in[3] = 1'b0;
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset mid coin", 32'(btn_out), 32'h000);
    @(negedge clk);
    check("coin cleared", 32'(btn_out), 32'h000);
    key_evt(1'b1, 9'h01C);
    check("default map restored old", 32'(key_state), 32'h000);
    key_evt(1'b1, KEY_F1);
    check("default map restored F1", 32'(key_state), 32'h002);
    key_evt(1'b0, KEY_F1);
    idle(2);

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      cfg_wr = 1'b0;
      reset  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) joy_in[$urandom_range(0, NS-1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 13)]};
      if ($urandom_range(0, 19) == 0) begin
        cfg_wr   = 1'b1;
        cfg_idx  = 4'($urandom_range(0, 15));
        cfg_code = codes[$urandom_range(0, 13)];
      end
      if ($urandom_range(0, 99) == 0) af_en = ~af_en;
      inputs_en = ($urandom_range(0, 49) != 0);
      @(negedge clk);
    end
    reset = 1'b0; cfg_wr = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
